// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: decoded stage fields in, pipeline controls and counters out.
// master: decode/pipeline side (drives stage fields, consumes controls).
// slave : hazard_ctrl (consumes stage fields, drives controls).
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       rs1_D, rs2_D;
  logic [4:0]       rs1_E, rs2_E;
  logic [4:0]       rd_E, rd_M, rd_W;
  logic             rd_wren_E, rd_wren_M, rd_wren_W;
  logic [1:0]       wb_sel_E;
  logic             br_sel_E;
  logic             lsu_req_M;
  logic             lsu_ready;
  logic             stall_F, stall_D, stall_E, stall_M;
  logic             flush_D, flush_E, flush_W;
  logic [1:0]       fwd_a_E, fwd_b_E;
  logic             err_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] redir_cnt;

  modport master (
    output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
    output rd_wren_E, rd_wren_M, rd_wren_W, wb_sel_E, br_sel_E, lsu_req_M, lsu_ready,
    input  stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
    input  fwd_a_E, fwd_b_E, err_timeout, stall_cnt, redir_cnt
  );

  modport slave (
    input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
    input  rd_wren_E, rd_wren_M, rd_wren_W, wb_sel_E, br_sel_E, lsu_req_M, lsu_ready,
    output stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
    output fwd_a_E, fwd_b_E, err_timeout, stall_cnt, redir_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer for the 5-stage RV32I core.
// Ports:
//   clk  - core clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - hazard_ctrl_if.slave: D/E/M/W stage fields in; stall/flush/forward
//          controls, sticky memory-timeout flag and stall/redirect counters out.
// Stall/flush controls are combinational so a one-cycle memory wait costs one stall.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
);
  localparam int unsigned WaitW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {StRun, StWait, StErr} state_e;

  state_e           state_q;
  logic [WaitW-1:0] wait_cnt_q;
  logic             err_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] redir_cnt_q;

  logic mem_busy, load_use, redir_take;

  // M result beats W; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic wren_m, input logic [4:0] rd_m,
                                         input logic wren_w, input logic [4:0] rd_w);
    if (wren_m && rd_m != 5'd0 && rd_m == rs) return 2'b10;
    if (wren_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    bus.fwd_a_E = fwd_sel(bus.rs1_E, bus.rd_wren_M, bus.rd_M, bus.rd_wren_W, bus.rd_W);
    bus.fwd_b_E = fwd_sel(bus.rs2_E, bus.rd_wren_M, bus.rd_M, bus.rd_wren_W, bus.rd_W);
  end

  assign mem_busy = bus.lsu_req_M && !bus.lsu_ready;
  assign load_use = (bus.wb_sel_E == 2'b01) && bus.rd_wren_E && (bus.rd_E != 5'd0) &&
                    ((bus.rd_E == bus.rs1_D) || (bus.rd_E == bus.rs2_D));

  always_comb begin
    bus.stall_F = 1'b0;
    bus.stall_D = 1'b0;
    bus.stall_E = 1'b0;
    bus.stall_M = 1'b0;
    bus.flush_D = 1'b0;
    bus.flush_E = 1'b0;
    bus.flush_W = 1'b0;
    redir_take  = 1'b0;
    if (rst) begin
      // Bubbles into D/E/W while reset is held.
      bus.flush_D = 1'b1;
      bus.flush_E = 1'b1;
      bus.flush_W = 1'b1;
    end else if (state_q == StErr || mem_busy) begin
      // Freeze F..M; redirect/load-use stay pending in their stages.
      bus.stall_F = 1'b1;
      bus.stall_D = 1'b1;
      bus.stall_E = 1'b1;
      bus.stall_M = 1'b1;
      bus.flush_W = 1'b1;
    end else if (bus.br_sel_E) begin
      bus.flush_D = 1'b1;
      bus.flush_E = 1'b1;
      redir_take  = 1'b1;
    end else if (load_use) begin
      bus.stall_F = 1'b1;
      bus.stall_D = 1'b1;
      bus.flush_E = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (mem_busy) begin
            state_q    <= StWait;
            wait_cnt_q <= WaitW'(1);
          end
        end
        StWait: begin
          if (mem_busy) begin
            if (wait_cnt_q == WaitLast) begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end else begin
              wait_cnt_q <= wait_cnt_q + WaitW'(1);
            end
          end else begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
          end
        end
        StErr:   state_q <= StErr;
        default: state_q <= StRun;
      endcase
      if (bus.stall_D) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (redir_take)  redir_cnt_q <= redir_cnt_q + CNT_W'(1);
    end
  end

  assign bus.err_timeout = err_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.redir_cnt   = redir_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(32)) bus ();
  hazard_ctrl_if #(.CNT_W(4))  b4 ();

  hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(b4));

  // Control vector {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W}
  localparam logic [6:0] VRst   = 7'b0000111;
  localparam logic [6:0] VIdle  = 7'b0000000;
  localparam logic [6:0] VBusy  = 7'b1111001;
  localparam logic [6:0] VRedir = 7'b0000110;
  localparam logic [6:0] VLu    = 7'b1100010;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned es = 0;
  int unsigned er = 0;
  logic        cur_sd = 1'b0;
  logic        cur_rd = 1'b0;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0: return {25'd0, bus.stall_F, bus.stall_D, bus.stall_E, bus.stall_M,
                 bus.flush_D, bus.flush_E, bus.flush_W};
      1: return {30'd0, bus.fwd_a_E};
      2: return {30'd0, bus.fwd_b_E};
      3: return {31'd0, bus.err_timeout};
      4: return bus.stall_cnt;
      5: return bus.redir_cnt;
      6: return {28'd0, b4.stall_cnt};
      default: return 32'hdeadbeef;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic exp_ctrl(input string tag, input logic [6:0] v);
    push(tag, 0, {25'd0, v});
    cur_sd = v[5];
    cur_rd = (v == VRedir);
  endtask

  task automatic exp_cnt(input string tag);
    push({tag, "_stall_cnt"}, 4, es);
    push({tag, "_redir_cnt"}, 5, er);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sel);
      checks++;
      assert (o === e.exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.exp);
      end
    end
  endtask

  // Check at negedge, then step one rising edge and update the counter model.
  task automatic cyc();
    @(negedge clk);
    drain();
    @(posedge clk);
    if (cur_sd) es++;
    if (cur_rd) er++;
    #1;
  endtask

  task automatic idle_inputs();
    bus.rs1_D = '0; bus.rs2_D = '0; bus.rs1_E = '0; bus.rs2_E = '0;
    bus.rd_E = '0; bus.rd_M = '0; bus.rd_W = '0;
    bus.rd_wren_E = 1'b0; bus.rd_wren_M = 1'b0; bus.rd_wren_W = 1'b0;
    bus.wb_sel_E = '0; bus.br_sel_E = 1'b0; bus.lsu_req_M = 1'b0; bus.lsu_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    b4.rs1_D = '0; b4.rs2_D = '0; b4.rs1_E = '0; b4.rs2_E = '0;
    b4.rd_E = '0; b4.rd_M = '0; b4.rd_W = '0;
    b4.rd_wren_E = 1'b0; b4.rd_wren_M = 1'b0; b4.rd_wren_W = 1'b0;
    b4.wb_sel_E = '0; b4.br_sel_E = 1'b0; b4.lsu_req_M = 1'b0; b4.lsu_ready = 1'b0;
    #2;
    push("rst_ctrl", 0, {25'd0, VRst});
    push("rst_fwd_a", 1, 0);
    push("rst_fwd_b", 2, 0);
    push("rst_err", 3, 0);
    exp_cnt("rst");
    drain();
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    exp_ctrl("idle", VIdle);
    cyc();

    // Forwarding: M beats W, x0 never forwarded, W alone, M not writing.
    bus.rd_M = 5; bus.rd_wren_M = 1'b1; bus.rd_W = 5; bus.rd_wren_W = 1'b1;
    bus.rs1_E = 5; bus.rs2_E = 0;
    exp_ctrl("fwd_ctrl", VIdle);
    push("fwd_a_m_over_w", 1, 2);
    push("fwd_b_rs0", 2, 0);
    cyc();
    bus.rd_M = 0; bus.rd_W = 0; bus.rs1_E = 0; bus.rs2_E = 0;
    push("fwd_a_x0", 1, 0);
    push("fwd_b_x0", 2, 0);
    cyc();
    bus.rd_M = 3; bus.rd_W = 9; bus.rs1_E = 9; bus.rs2_E = 3;
    push("fwd_a_w", 1, 1);
    push("fwd_b_m", 2, 2);
    cyc();
    bus.rd_wren_M = 1'b0; bus.rd_M = 9; bus.rs1_E = 9; bus.rs2_E = 4;
    push("fwd_a_m_nowren", 1, 1);
    push("fwd_b_none", 2, 0);
    cyc();
    idle_inputs();

    // Load-use on rs2: one stall cycle.
    bus.wb_sel_E = 2'b01; bus.rd_wren_E = 1'b1; bus.rd_E = 7; bus.rs2_D = 7;
    exp_ctrl("lu", VLu);
    cyc();
    idle_inputs();
    exp_ctrl("lu_after", VIdle);
    exp_cnt("lu");
    cyc();

    // Not a load, and rd_E=x0: no stall.
    bus.wb_sel_E = 2'b00; bus.rd_wren_E = 1'b1; bus.rd_E = 7; bus.rs1_D = 7;
    exp_ctrl("lu_not_load", VIdle);
    cyc();
    bus.wb_sel_E = 2'b01; bus.rd_E = 0; bus.rs1_D = 0;
    exp_ctrl("lu_x0", VIdle);
    cyc();
    idle_inputs();

    // Redirect overrides load-use.
    bus.wb_sel_E = 2'b01; bus.rd_wren_E = 1'b1; bus.rd_E = 7; bus.rs2_D = 7;
    bus.br_sel_E = 1'b1;
    exp_ctrl("redir_lu", VRedir);
    cyc();
    idle_inputs();
    exp_ctrl("redir_after", VIdle);
    exp_cnt("redir");
    cyc();

    // Three-cycle memory wait with a redirect held pending.
    bus.lsu_req_M = 1'b1; bus.lsu_ready = 1'b0; bus.br_sel_E = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_ctrl("busy3", VBusy);
      cyc();
    end
    bus.lsu_ready = 1'b1;
    exp_ctrl("busy3_release", VRedir);
    push("busy3_err", 3, 0);
    cyc();
    idle_inputs();
    exp_ctrl("busy3_after", VIdle);
    exp_cnt("busy3");
    cyc();

    // Timeout: 16 busy cycles enter ERR, which holds even after ready.
    bus.lsu_req_M = 1'b1; bus.lsu_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_ctrl("to_busy", VBusy);
      push("to_err_pre", 3, 0);
      cyc();
    end
    bus.lsu_ready = 1'b1;
    exp_ctrl("err_ready", VBusy);
    push("err_set", 3, 1);
    cyc();
    bus.lsu_req_M = 1'b0;
    exp_ctrl("err_hold", VBusy);
    push("err_hold_flag", 3, 1);
    exp_cnt("err");
    cyc();

    // Asynchronous reset in the middle of ERR.
    #2 rst = 1'b1;
    #1;
    es = 0;
    er = 0;
    push("arst_ctrl", 0, {25'd0, VRst});
    push("arst_err", 3, 0);
    exp_cnt("arst");
    drain();
    cur_sd = 1'b0;
    cur_rd = 1'b0;
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    exp_ctrl("post_rst", VIdle);
    push("post_rst_err", 3, 0);
    cyc();
    exp_ctrl("post_rst2", VIdle);
    push("post_rst2_err", 3, 0);
    exp_cnt("post_rst");
    cyc();

    // 4-bit counter build: 17 stall cycles wrap to 1.
    b4.lsu_req_M = 1'b1;
    b4.lsu_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      exp_ctrl("wrap_main_idle", VIdle);
      cyc();
    end
    b4.lsu_req_M = 1'b0;
    push("wrap_stall_cnt", 6, 1);
    exp_ctrl("wrap_end", VIdle);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
